// File: rtl/cnn_sched_pkg.sv
// rtl/cnn_sched_pkg.sv - shared state encoding and default widths for the convolution window scheduler
//
// Purpose: common definitions imported by conv_window_scheduler.
// Ports:   none (package).

package cnn_sched_pkg;

    localparam int SCHED_DIM_W  = 10;
    localparam int SCHED_ADDR_W = 16;
    localparam int SCHED_K_W    = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } sched_state_t;

endpackage

// File: rtl/sched_axis_counter.sv
// rtl/sched_axis_counter.sv - falling-edge loadable counter with equality flag
//
// Purpose: one axis of the convolution sweep (kc, kr, c or r).
// Ports:
//   clk        in   counter clock, state changes on falling edge
//   clr        in   asynchronous active-low clear
//   en         in   increment by one
//   load       in   load load_value (has priority over en)
//   load_value in   value loaded when load=1
//   limit      in   comparison value for at_limit
//   count      out  current count
//   at_limit   out  count == limit

module sched_axis_counter #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             at_limit
);

    always_ff @(negedge clk or negedge clr) begin
        if (!clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

    assign at_limit = (count == limit);

endmodule

// File: rtl/conv_window_scheduler.sv
// rtl/conv_window_scheduler.sv - read-address sequencer for a stride-1 KxK convolution sweep
//
// Purpose: walks every KxK window of a WxH row-major feature map and emits one
//          element address per accepted valid/ready transfer, with window
//          first/last markers for the MAC accumulator.
// Ports:
//   COUNTER_Clk    in   clock, all state changes on falling edge
//   COUNTER_Clr    in   asynchronous active-low reset
//   SCH_Start      in   start request (IDLE only)
//   SCH_Width      in   image width W
//   SCH_Height     in   image height H
//   SCH_Ksize      in   kernel size K
//   SCH_Base       in   address of pixel (0,0)
//   SCH_Rd_Ready   in   consumer accepts current address
//   SCH_Rd_Valid   out  SCH_Rd_Addr is valid
//   SCH_Rd_Addr    out  element address
//   SCH_Win_First  out  element is (0,0) of its window
//   SCH_Win_Last   out  element is (K-1,K-1) of its window
//   SCH_Win_Row    out  output row of current window
//   SCH_Win_Col    out  output column of current window
//   SCH_Busy       out  high in ISSUE and DONE
//   SCH_Done       out  one-cycle end-of-sweep pulse
//   SCH_Err        out  configuration error, valid with SCH_Done

module conv_window_scheduler
    import cnn_sched_pkg::*;
#(
    parameter int DIM_W  = SCHED_DIM_W,
    parameter int ADDR_W = SCHED_ADDR_W,
    parameter int K_W    = SCHED_K_W
) (
    input  logic              COUNTER_Clk,
    input  logic              COUNTER_Clr,
    input  logic              SCH_Start,
    input  logic [DIM_W-1:0]  SCH_Width,
    input  logic [DIM_W-1:0]  SCH_Height,
    input  logic [K_W-1:0]    SCH_Ksize,
    input  logic [ADDR_W-1:0] SCH_Base,
    input  logic              SCH_Rd_Ready,
    output logic              SCH_Rd_Valid,
    output logic [ADDR_W-1:0] SCH_Rd_Addr,
    output logic              SCH_Win_First,
    output logic              SCH_Win_Last,
    output logic [DIM_W-1:0]  SCH_Win_Row,
    output logic [DIM_W-1:0]  SCH_Win_Col,
    output logic              SCH_Busy,
    output logic              SCH_Done,
    output logic              SCH_Err
);

    sched_state_t state_q, state_d;

    logic [DIM_W-1:0]  w_q, ow_q, oh_q;
    logic [K_W-1:0]    k_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q, win_ptr_q, row_ptr_q;

    logic [K_W-1:0]    kc, kr;
    logic [DIM_W-1:0]  c, r;
    logic              kc_end, kr_end, c_end, r_end;

    logic [DIM_W-1:0]  k_dim;
    logic              cfg_bad;
    logic              start_ok;
    logic              xfer;
    logic              win_end;
    logic              sweep_end;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] row_step;
    logic [ADDR_W-1:0] next_row;

    assign k_dim    = DIM_W'(SCH_Ksize);
    assign cfg_bad  = (SCH_Ksize == '0) || (k_dim > SCH_Width) || (k_dim > SCH_Height);
    assign start_ok = (state_q == ST_IDLE) && SCH_Start && !cfg_bad;
    assign xfer     = (state_q == ST_ISSUE) && SCH_Rd_Ready;
    assign win_end  = xfer && kc_end && kr_end;
    assign sweep_end = win_end && c_end && r_end;

    // Jump from the last column of one kernel row to the first column of the
    // next: W-(K-1), formed without a multiplier.
    assign w_addr   = ADDR_W'(w_q);
    assign row_step = w_addr - ADDR_W'(k_q) + ADDR_W'(1);
    assign next_row = row_ptr_q + w_addr;

    // Every counter is also cleared on a good start so a new sweep never
    // inherits positions from an aborted or earlier one.
    sched_axis_counter #(.WIDTH(K_W)) u_kc (
        .clk        (COUNTER_Clk),
        .clr        (COUNTER_Clr),
        .en         (xfer && !kc_end),
        .load       (start_ok || (xfer && kc_end)),
        .load_value ('0),
        .limit      (k_q - K_W'(1)),
        .count      (kc),
        .at_limit   (kc_end)
    );

    sched_axis_counter #(.WIDTH(K_W)) u_kr (
        .clk        (COUNTER_Clk),
        .clr        (COUNTER_Clr),
        .en         (xfer && kc_end && !kr_end),
        .load       (start_ok || win_end),
        .load_value ('0),
        .limit      (k_q - K_W'(1)),
        .count      (kr),
        .at_limit   (kr_end)
    );

    sched_axis_counter #(.WIDTH(DIM_W)) u_c (
        .clk        (COUNTER_Clk),
        .clr        (COUNTER_Clr),
        .en         (win_end && !c_end),
        .load       (start_ok || (win_end && c_end)),
        .load_value ('0),
        .limit      (ow_q - DIM_W'(1)),
        .count      (c),
        .at_limit   (c_end)
    );

    sched_axis_counter #(.WIDTH(DIM_W)) u_r (
        .clk        (COUNTER_Clk),
        .clr        (COUNTER_Clr),
        .en         (win_end && c_end && !r_end),
        .load       (start_ok || sweep_end),
        .load_value ('0),
        .limit      (oh_q - DIM_W'(1)),
        .count      (r),
        .at_limit   (r_end)
    );

    always_ff @(negedge COUNTER_Clk or negedge COUNTER_Clr) begin
        if (!COUNTER_Clr) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        SCH_Rd_Valid  = 1'b0;
        SCH_Busy      = 1'b0;
        SCH_Done      = 1'b0;
        SCH_Win_First = 1'b0;
        SCH_Win_Last  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (SCH_Start) begin
                    state_d = cfg_bad ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                SCH_Rd_Valid  = 1'b1;
                SCH_Busy      = 1'b1;
                SCH_Win_First = (kc == '0) && (kr == '0);
                SCH_Win_Last  = kc_end && kr_end;
                if (sweep_end) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                SCH_Busy = 1'b1;
                SCH_Done = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(negedge COUNTER_Clk or negedge COUNTER_Clr) begin
        if (!COUNTER_Clr) begin
            w_q       <= '0;
            ow_q      <= '0;
            oh_q      <= '0;
            k_q       <= '0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            win_ptr_q <= '0;
            row_ptr_q <= '0;
        end else if (state_q == ST_IDLE) begin
            if (SCH_Start) begin
                w_q   <= SCH_Width;
                k_q   <= SCH_Ksize;
                ow_q  <= SCH_Width - k_dim + DIM_W'(1);
                oh_q  <= SCH_Height - k_dim + DIM_W'(1);
                err_q <= cfg_bad;
                if (!cfg_bad) begin
                    addr_q    <= SCH_Base;
                    win_ptr_q <= SCH_Base;
                    row_ptr_q <= SCH_Base;
                end
            end
        end else if (xfer) begin
            if (!kc_end) begin
                addr_q <= addr_q + ADDR_W'(1);
            end else if (!kr_end) begin
                addr_q <= addr_q + row_step;
            end else if (!c_end) begin
                win_ptr_q <= win_ptr_q + ADDR_W'(1);
                addr_q    <= win_ptr_q + ADDR_W'(1);
            end else if (!r_end) begin
                row_ptr_q <= next_row;
                win_ptr_q <= next_row;
                addr_q    <= next_row;
            end
        end
    end

    assign SCH_Rd_Addr = addr_q;
    assign SCH_Win_Row = r;
    assign SCH_Win_Col = c;
    assign SCH_Err     = err_q;

endmodule

// File: tb/tb_conv_window_scheduler.sv
// tb/tb_conv_window_scheduler.sv - self-checking bench for conv_window_scheduler

module tb_conv_window_scheduler;

    logic        clk;
    logic        clr;
    logic        start;
    logic [9:0]  width;
    logic [9:0]  height;
    logic [2:0]  ksize;
    logic [15:0] base;
    logic        ready;
    logic        valid;
    logic [15:0] addr;
    logic        first;
    logic        last;
    logic [9:0]  win_row;
    logic [9:0]  win_col;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int addr;
        int first;
        int last;
        int row;
        int col;
    } exp_t;

    exp_t exp_q[$];

    conv_window_scheduler dut (
        .COUNTER_Clk   (clk),
        .COUNTER_Clr   (clr),
        .SCH_Start     (start),
        .SCH_Width     (width),
        .SCH_Height    (height),
        .SCH_Ksize     (ksize),
        .SCH_Base      (base),
        .SCH_Rd_Ready  (ready),
        .SCH_Rd_Valid  (valid),
        .SCH_Rd_Addr   (addr),
        .SCH_Win_First (first),
        .SCH_Win_Last  (last),
        .SCH_Win_Row   (win_row),
        .SCH_Win_Col   (win_col),
        .SCH_Busy      (busy),
        .SCH_Done      (done),
        .SCH_Err       (err)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Reference: every window in raster order, elements in raster order inside
    // the window, address = base + (r+kr)*W + (c+kc) modulo 2^16.
    task automatic build_model(input int w, input int h, input int k, input int b);
        exp_t e;
        exp_q.delete();
        for (int r = 0; r < h - k + 1; r++)
            for (int c = 0; c < w - k + 1; c++)
                for (int kr = 0; kr < k; kr++)
                    for (int kc = 0; kc < k; kc++) begin
                        e.addr  = (b + (r + kr) * w + (c + kc)) & 32'hFFFF;
                        e.first = (kr == 0 && kc == 0) ? 1 : 0;
                        e.last  = (kr == k - 1 && kc == k - 1) ? 1 : 0;
                        e.row   = r;
                        e.col   = c;
                        exp_q.push_back(e);
                    end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_valid"}, valid, 0);
        check_eq({tag, "_addr"}, addr, 0);
        check_eq({tag, "_first"}, first, 0);
        check_eq({tag, "_last"}, last, 0);
        check_eq({tag, "_row"}, win_row, 0);
        check_eq({tag, "_col"}, win_col, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_err"}, err, 0);
    endtask

    task automatic run_sweep(input int w, input int h, input int k, input int b,
                             input int stall_pct, input int busy_start_at, input int abort_at);
        int n;
        int idx;
        int budget;
        bit stalled;
        bit finished;
        bit aborted;
        logic [15:0] prev_addr;
        build_model(w, h, k, b);
        n = exp_q.size();
        budget = n * 8 + 20;
        idx = 0;
        stalled = 0;
        finished = 0;
        aborted = 0;
        prev_addr = '0;
        @(posedge clk);
        width  = w[9:0];
        height = h[9:0];
        ksize  = k[2:0];
        base   = b[15:0];
        start  = 1'b1;
        ready  = 1'b1;
        @(posedge clk);
        start = 1'b0;
        // change config after latch; must have no effect
        width  = 10'd7;
        base   = 16'h5555;
        check_eq("start_err_clear", err, 0);
        check_eq("start_busy", busy, 1);
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (cyc > 0) @(posedge clk);
            start = 1'b0;
            if (abort_at >= 0 && idx == abort_at) begin
                clr = 1'b0;
                #1;
                check_all_zero("abort");
                #1;
                clr   = 1'b1;
                ready = 1'b0;
                @(posedge clk);
                check_eq("abort_idle_busy", busy, 0);
                check_eq("abort_no_done", done, 0);
                @(posedge clk);
                check_eq("abort_no_done2", done, 0);
                check_eq("abort_valid", valid, 0);
                aborted = 1;
                break;
            end
            if (idx == n) begin
                check_eq("xfer_count", idx, n);
                check_eq("done_pulse", done, 1);
                check_eq("done_err", err, 0);
                check_eq("done_valid", valid, 0);
                @(posedge clk);
                check_eq("done_one_cycle", done, 0);
                check_eq("busy_after_done", busy, 0);
                finished = 1;
                break;
            end
            check_eq("valid", valid, 1);
            check_eq("no_early_done", done, 0);
            check_eq("addr", addr, exp_q[idx].addr);
            check_eq("first", first, exp_q[idx].first);
            check_eq("last", last, exp_q[idx].last);
            check_eq("win_row", win_row, exp_q[idx].row);
            check_eq("win_col", win_col, exp_q[idx].col);
            if (stalled) check_eq("hold_addr", addr, prev_addr);
            if (idx == busy_start_at) begin
                start  = 1'b1;
                ksize  = 3'd1;
                base   = 16'h0ABC;
            end
            prev_addr = addr;
            ready = ($urandom_range(99) >= stall_pct);
            if (ready) begin
                idx++;
                stalled = 0;
            end else begin
                stalled = 1;
            end
        end
        if (!finished && !aborted) check_eq("sweep_timeout", idx, n + 1);
    endtask

    task automatic run_error(input int w, input int h, input int k);
        @(posedge clk);
        width  = w[9:0];
        height = h[9:0];
        ksize  = k[2:0];
        base   = 16'h0100;
        start  = 1'b1;
        ready  = 1'b1;
        @(posedge clk);
        start = 1'b0;
        check_eq("err_done", done, 1);
        check_eq("err_flag", err, 1);
        check_eq("err_valid", valid, 0);
        @(posedge clk);
        check_eq("err_done_end", done, 0);
        check_eq("err_valid2", valid, 0);
        check_eq("err_busy_end", busy, 0);
    endtask

    initial begin
        int w;
        int h;
        int k;
        int kmax;
        clr    = 1'b0;
        start  = 1'b0;
        width  = '0;
        height = '0;
        ksize  = '0;
        base   = '0;
        ready  = 1'b0;
        #2;
        check_all_zero("reset");
        @(posedge clk);
        clr = 1'b1;

        build_model(4, 4, 3, 32'h100);
        check_eq("model_count_4x4k3", exp_q.size(), 36);
        run_sweep(4, 4, 3, 32'h100, 0, -1, -1);
        run_sweep(4, 4, 3, 32'h100, 50, -1, -1);
        run_sweep(3, 2, 1, 0, 0, -1, -1);
        run_error(4, 4, 5);
        run_sweep(2, 2, 1, 32'hFFFE, 0, -1, -1);
        run_sweep(4, 4, 3, 32'h100, 30, 4, 10);
        run_sweep(4, 4, 3, 32'h100, 0, -1, -1);
        run_error(4, 4, 0);
        run_error(6, 2, 3);
        for (int t = 0; t < 8; t++) begin
            w = $urandom_range(1, 8);
            h = $urandom_range(1, 8);
            kmax = (w < h) ? w : h;
            if (kmax > 7) kmax = 7;
            k = $urandom_range(1, kmax);
            run_sweep(w, h, k, $urandom_range(0, 65535), 30, 2, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
